instr_fetch: RTL and testbench

Fetch-side initiator for the instruction memory. Holds the program counter and drives the word-aligned byte address to the combinational imem read port. Captures each returned instruction with its PC in a small FIFO and presents {pc, instr} to decode over a valid/ready handshake. Handles branch/jump redirects, halts after EBREAK, and traps misaligned redirect targets.

---
 rtl/instr_fetch.sv | 189 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Fetch-side initiator for the instruction memory.
//
// The block holds the program counter and drives it as the word-aligned byte
// address of a combinational imem read port. Each returned word is stored in a
// small FIFO together with its PC. Decode takes {pc, instr} from the FIFO over
// a valid/ready handshake.
//
// Fetch has three states:
//   RUN   - fetching allowed
//   HALT  - entered after an EBREAK is pushed
//   FAULT - entered on a misaligned redirect target
//
// A redirect has the highest priority. It flushes the FIFO and reloads the PC.
// An aligned redirect returns to RUN from any state.
//
// Optional feature: define INSTR_FETCH_PERF_EN to add saturating fetch and
// stall counters (fetch_cnt_o, stall_cnt_o).
//
// Ports:
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   fetch_en_i    in   fetch allowed (low blocks pushes only)
//   addr_o        out  byte address to imem (= PC)
//   instr_i       in   instruction from imem, valid in the same cycle
//   redirect_i    in   branch/jump/trap redirect strobe
//   redirect_pc_i in   redirect target byte address
//   valid_o       out  head FIFO entry valid
//   ready_i       in   decode accepts head entry
//   pc_o          out  PC of head entry (0 when empty)
//   instr_o       out  instruction of head entry (0 when empty)
//   halted_o      out  state is HALT
//   fault_o       out  state is FAULT
//   fetch_cnt_o   out  (INSTR_FETCH_PERF_EN) pushes, saturating
//   stall_cnt_o   out  (INSTR_FETCH_PERF_EN) full-FIFO stall cycles, saturating
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'h0010_0073
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en_i,
    output logic [DATA_WIDTH-1:0] addr_o,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  halted_o,
`ifdef INSTR_FETCH_PERF_EN
    output logic                  fault_o,
    output logic [31:0]           fetch_cnt_o,
    output logic [31:0]           stall_cnt_o
`else
    output logic                  fault_o
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    // Storage needs no reset; the outputs are gated by r_count.
    logic [DATA_WIDTH-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_instr [FIFO_DEPTH];

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_misaligned;
    logic [DATA_WIDTH-1:0] w_redirect_aligned;

    assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
    assign valid_o = (r_count != '0);

    // A redirect cycle neither pushes nor pops. A head entry offered during
    // a redirect is therefore not accepted.
    assign w_push = (r_state == S_RUN) && fetch_en_i && !redirect_i && !w_full;
    assign w_pop  = valid_o && ready_i && !redirect_i;

    assign w_misaligned       = (redirect_pc_i[1:0] != 2'b00);
    assign w_redirect_aligned = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};

    assign addr_o   = r_pc;
    assign pc_o     = valid_o ? r_fifo_pc[r_rd_ptr]    : '0;
    assign instr_o  = valid_o ? r_fifo_instr[r_rd_ptr] : '0;
    assign halted_o = (r_state == S_HALT);
    assign fault_o  = (r_state == S_FAULT);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect_i) begin
            w_state_next = w_misaligned ? S_FAULT : S_RUN;
        end else if (w_push && (instr_i == HALT_INSTR)) begin
            // The EBREAK word itself is still enqueued this cycle.
            w_state_next = S_HALT;
        end
    end

    // ---------------- PC and FIFO control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_i) begin
            r_pc     <= w_redirect_aligned;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + DATA_WIDTH'(4);
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_pc;
            r_fifo_instr[r_wr_ptr] <= instr_i;
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    // ---------------- saturating performance counters ----------------
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (r_state == S_RUN) && fetch_en_i && w_full && !redirect_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_push && (r_fetch_cnt != '1)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. A behavioural model is kept as a queue
// of {pc, instr} entries, a model PC and a model state. Each cycle it is
// updated from the fetch rules, and every DUT output is compared with it
// one time unit after the active edge. The imem is a small array indexed by
// address bits [11:2]. One EBREAK word is placed at 0xE4.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int          DW    = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] HALT  = 32'h0010_0073;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_en_i;
    logic [DW-1:0] addr_o;
    logic [DW-1:0] instr_i;
    logic          redirect_i;
    logic [DW-1:0] redirect_pc_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] pc_o;
    logic [DW-1:0] instr_o;
    logic          halted_o;
    logic          fault_o;
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0]   fetch_cnt_o;
    logic [31:0]   stall_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    assign instr_i = mem[addr_o[11:2]];

    instr_fetch #(
        .DATA_WIDTH (DW),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (DEPTH),
        .HALT_INSTR (HALT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en_i    (fetch_en_i),
        .addr_o        (addr_o),
        .instr_i       (instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .pc_o          (pc_o),
        .instr_o       (instr_o),
        .halted_o      (halted_o),
`ifdef INSTR_FETCH_PERF_EN
        .fault_o       (fault_o),
        .fetch_cnt_o   (fetch_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
`else
        .fault_o       (fault_o)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    int          m_state;     // 0 = run, 1 = halt, 2 = fault
    logic [31:0] m_fetches;
    logic [31:0] m_stalls;

    task automatic model_reset();
        q.delete();
        m_pc      = 32'h0;
        m_state   = 0;
        m_fetches = 0;
        m_stalls  = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("addr_o",   addr_o,          m_pc);
        check("valid_o",  {31'd0, valid_o}, {31'd0, q.size() != 0});
        check("pc_o",     pc_o,            (q.size() != 0) ? q[0].pc : 32'h0);
        check("instr_o",  instr_o,         (q.size() != 0) ? q[0].instr : 32'h0);
        check("halted_o", {31'd0, halted_o}, {31'd0, m_state == 1});
        check("fault_o",  {31'd0, fault_o},  {31'd0, m_state == 2});
`ifdef INSTR_FETCH_PERF_EN
        check("fetch_cnt_o", fetch_cnt_o, m_fetches);
        check("stall_cnt_o", stall_cnt_o, m_stalls);
`endif
    endtask

    // One clock cycle. The model is advanced using the pre-edge state and
    // inputs, and the DUT is then sampled 1 time unit after the edge.
    task automatic cycle(input logic rdy, input logic en, input logic redir,
                         input logic [31:0] rpc);
        logic        push;
        logic [31:0] ins;
        ready_i       = rdy;
        fetch_en_i    = en;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        ins = mem[m_pc[11:2]];
        if (redir) begin
            q.delete();
            m_pc    = {rpc[31:2], 2'b00};
            m_state = (rpc[1:0] == 2'b00) ? 0 : 2;
        end else begin
            push = (m_state == 0) && en && (q.size() < DEPTH);
            if ((m_state == 0) && en && (q.size() == DEPTH) && m_stalls != 32'hFFFF_FFFF)
                m_stalls++;
            if (q.size() != 0 && rdy)
                void'(q.pop_front());
            if (push) begin
                q.push_back('{pc: m_pc, instr: ins});
                if (ins == HALT) m_state = 1;
                m_pc = m_pc + 32'd4;
                if (m_fetches != 32'hFFFF_FFFF) m_fetches++;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n, input logic rdy, input logic en);
        for (int i = 0; i < n; i++) cycle(rdy, en, 1'b0, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT) mem[i] = 32'h0000_0013;
        end
        mem[0]          = 32'h0010_0093;
        mem[1]          = 32'h0020_0113;
        mem[32'hE4 >> 2] = HALT;

        rst_n = 1'b0; ready_i = 1'b1; fetch_en_i = 1'b1;
        redirect_i = 1'b0; redirect_pc_i = 32'h0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // Streaming with ready high: addr 0x4, 0x8; heads 0x0 then 0x4.
        cycle(1, 1, 0, 32'h0);
        check("first_instr", instr_o, 32'h0010_0093);
        cycle(1, 1, 0, 32'h0);
        check("second_pc", pc_o, 32'h4);

        // Back-pressure: FIFO fills, PC holds.
        run(5, 0, 1);
        check("full_addr_hold", addr_o, 32'hC);
        run(3, 1, 1);

        // Redirect with 2 entries queued.
        run(2, 0, 1);
        cycle(1, 1, 1, 32'hDC);
        check("redir_valid", {31'd0, valid_o}, 32'd0);
        check("redir_addr", addr_o, 32'hDC);
        cycle(1, 1, 0, 32'h0);
        check("redir_head", pc_o, 32'hDC);

        // Fetch reaches EBREAK at 0xE4, halts and drains.
        run(6, 1, 1);
        check("halt_flag", {31'd0, halted_o}, 32'd1);
        check("halt_addr", addr_o, 32'hE8);
        cycle(1, 1, 1, 32'h0);
        run(3, 1, 1);

        // Misaligned redirect traps; aligned redirect recovers.
        cycle(1, 1, 1, 32'h42);
        check("fault_addr", addr_o, 32'h40);
        run(3, 1, 1);
        cycle(1, 1, 1, 32'h40);
        run(3, 1, 1);

        // PC wrap-around and fetch_en low.
        cycle(1, 1, 1, 32'hFFFF_FFFC);
        run(3, 1, 1);
        run(3, 1, 0);

        // Full-FIFO stalls, then a drain.
        cycle(1, 1, 1, 32'h100);
        run(5, 0, 1);
        run(3, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic        r, e, d;
            logic [31:0] t;
            r = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 4) != 0);
            d = ($urandom_range(0, 15) == 0);
            t = $urandom_range(0, 32'hFFF);
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            cycle(r, e, d, t);
        end

        // Asynchronous reset mid-stream.
        run(2, 0, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
        run(5, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
